// File: rtl/sdram_port_client.sv
// Requester side of one SDRAM controller port.
// Converts a host valid/ready request stream into the controller's toggle
// req/ack handshake. Writes are posted into a small FIFO; a read is latched
// into a single slot and only issued once every earlier write has completed.
// Ports:
//   clk, reset                       clock, async active-high reset
//   host_valid/ready/we/addr/be/wdata host request channel
//   host_rdata/host_rvalid           read return (1-cycle pulse)
//   idle                             nothing queued, nothing in flight
//   err_timeout                      sticky watchdog expiry flag
//   sd_addr/wrl/wrh/din/dout/req/ack controller port (req/ack toggle)
module sdram_port_client #(
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [23:0] host_addr,
  input  logic [1:0]  host_be,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  output logic        idle,
  output logic        err_timeout,
  output logic [23:0] sd_addr,
  output logic        sd_wrl,
  output logic        sd_wrh,
  output logic [15:0] sd_din,
  input  logic [15:0] sd_dout,
  output logic        sd_req,
  input  logic        sd_ack
);

  localparam int unsigned PW = $clog2(WFIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  be;
    logic [15:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {SYNC, IDLE, WR, RD} state_t;

  state_t      state_q, state_d;
  wr_entry_t   fifo_mem [WFIFO_DEPTH];
  wr_entry_t   head;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic        rd_full_q, rd_full_d;
  logic [23:0] rd_addr_q;
  logic        fifo_full, fifo_empty, rd_done, pop, push, rd_accept, slot_free;
  logic        err_d, sd_req_d, sd_wrl_d, sd_wrh_d, host_rvalid_d;
  logic [23:0] sd_addr_d;
  logic [15:0] sd_din_d, host_rdata_d;

  // Acceptance is decided from registered state; a full FIFO still accepts
  // when the head is being popped this cycle, and the read slot is free on
  // the completion cycle of the read it holds.
  always_comb begin
    fifo_full  = (count_q == CW'(WFIFO_DEPTH));
    fifo_empty = (count_q == '0);
    rd_done    = (state_q == RD) && (sd_ack == sd_req);
    pop        = (state_q == IDLE) && !fifo_empty;
    slot_free  = !rd_full_q || rd_done;
    host_ready = (state_q != SYNC) && slot_free && (!host_we || !fifo_full || pop);
    push       = host_valid && host_ready && host_we;
    rd_accept  = host_valid && host_ready && !host_we;
    idle       = (state_q == IDLE) && fifo_empty && !rd_full_q;
    head       = fifo_mem[rd_ptr_q];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    sd_req_d      = sd_req;
    sd_addr_d     = sd_addr;
    sd_din_d      = sd_din;
    sd_wrl_d      = sd_wrl;
    sd_wrh_d      = sd_wrh;
    host_rdata_d  = host_rdata;
    host_rvalid_d = 1'b0;
    rd_full_d     = rd_full_q;
    wdog_d        = wdog_q;
    err_d         = err_timeout;
    count_d       = count_q;

    unique case (state_q)
      SYNC: begin
        // ack is not reset by the controller; adopt it so no access starts
        sd_req_d = sd_ack;
        state_d  = IDLE;
      end
      IDLE: begin
        if (pop) begin
          sd_addr_d              = head.addr;
          sd_din_d               = head.data;
          {sd_wrh_d, sd_wrl_d}   = head.be;
          sd_req_d               = ~sd_req;
          wdog_d                 = '0;
          state_d                = WR;
        end else if (rd_full_q) begin
          sd_addr_d              = rd_addr_q;
          {sd_wrh_d, sd_wrl_d}   = 2'b00;
          sd_req_d               = ~sd_req;
          wdog_d                 = '0;
          state_d                = RD;
        end
      end
      WR, RD: begin
        if (sd_ack == sd_req) begin
          state_d = IDLE;
          if (state_q == RD) begin
            host_rdata_d  = sd_dout;
            host_rvalid_d = 1'b1;
            rd_full_d     = 1'b0;
          end
        end else if (wdog_q != TW'(TIMEOUT)) begin
          wdog_d = TW'(wdog_q + 1'b1);
          if (wdog_q == TW'(TIMEOUT - 1)) err_d = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    if (rd_accept) rd_full_d = 1'b1;

    if (push && !pop)      count_d = CW'(count_q + 1'b1);
    else if (!push && pop) count_d = CW'(count_q - 1'b1);
  end

  // State and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wdog_q      <= '0;
      rd_full_q   <= 1'b0;
      rd_addr_q   <= '0;
      err_timeout <= 1'b0;
      sd_req      <= 1'b0;
      sd_addr     <= '0;
      sd_din      <= '0;
      sd_wrl      <= 1'b0;
      sd_wrh      <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wdog_q      <= wdog_d;
      rd_full_q   <= rd_full_d;
      err_timeout <= err_d;
      sd_req      <= sd_req_d;
      sd_addr     <= sd_addr_d;
      sd_din      <= sd_din_d;
      sd_wrl      <= sd_wrl_d;
      sd_wrh      <= sd_wrh_d;
      host_rdata  <= host_rdata_d;
      host_rvalid <= host_rvalid_d;
      if (push)      wr_ptr_q  <= PW'(wr_ptr_q + 1'b1);
      if (pop)       rd_ptr_q  <= PW'(rd_ptr_q + 1'b1);
      if (rd_accept) rd_addr_q <= host_addr;
    end
  end

  // Posted-write storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: host_addr, be: host_be, data: host_wdata};
  end

endmodule

// File: tb/tb_sdram_port_client.sv
// Bench for sdram_port_client: directed host traffic, a behavioural
// controller port with a small memory, and a scoreboard monitor that checks
// every req toggle and every read return against queued expectations.
module tb_sdram_port_client;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_we = 1'b0;
  logic [23:0] host_addr = '0;
  logic [1:0]  host_be = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        idle;
  logic        err_timeout;
  logic [23:0] sd_addr;
  logic        sd_wrl, sd_wrh;
  logic [15:0] sd_din;
  logic [15:0] sd_dout = '0;
  logic        sd_req;
  logic        sd_ack = 1'b0;

  sdram_port_client #(.WFIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_be(host_be), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .idle(idle), .err_timeout(err_timeout),
    .sd_addr(sd_addr), .sd_wrl(sd_wrl), .sd_wrh(sd_wrh), .sd_din(sd_din),
    .sd_dout(sd_dout), .sd_req(sd_req), .sd_ack(sd_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  be;
    logic [15:0] din;
    logic        is_rd;
  } tog_t;

  tog_t        exp_tog[$];
  logic [15:0] exp_rd[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          tog_cnt = 0;
  int          tog_cyc = 0;
  int          rvalid_cnt = 0;
  bit          mon_en = 1'b0;
  bit          ack_hold = 1'b0;
  bit          ack_preset_en = 1'b0;
  logic        ack_preset = 1'b0;
  int          ack_lat = 2;
  logic [15:0] mem [logic [23:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller port model: acks each toggle after ack_lat cycles.
  int lat = 0;
  always @(posedge clk) begin
    logic [15:0] w;
    #1;
    if (rst) begin
      lat = 0;
      if (ack_preset_en) sd_ack = ack_preset;
    end else if (!ack_hold && sd_req != sd_ack) begin
      if (lat >= ack_lat) begin
        w = mem.exists(sd_addr) ? mem[sd_addr] : 16'h0000;
        if ({sd_wrh, sd_wrl} == 2'b00) sd_dout = w;
        else begin
          if (sd_wrl) w[7:0]  = sd_din[7:0];
          if (sd_wrh) w[15:8] = sd_din[15:8];
          mem[sd_addr] = w;
        end
        sd_ack = sd_req;
        lat = 0;
      end else lat++;
    end else lat = 0;
  end

  // Scoreboard monitor: toggles and read returns.
  logic prev_req = 1'b0;
  bit   in_flight = 1'b0;
  tog_t cur;
  always @(posedge clk) begin
    #2;
    if (!mon_en) begin
      prev_req  = sd_req;
      in_flight = 1'b0;
    end else if (sd_req != prev_req) begin
      chk("toggle_while_busy", 32'(in_flight), 32'd0);
      tog_cnt++;
      tog_cyc  = cyc;
      prev_req = sd_req;
      checks++;
      if (exp_tog.size() == 0) begin
        failures++;
        $display("FAIL unexpected_toggle actual addr=0x%0h required=no toggle", sd_addr);
        in_flight = 1'b0;
      end else begin
        cur = exp_tog.pop_front();
        chk("tog_addr", 32'(sd_addr), 32'(cur.addr));
        chk("tog_be", 32'({sd_wrh, sd_wrl}), 32'(cur.be));
        if (!cur.is_rd) chk("tog_din", 32'(sd_din), 32'(cur.din));
        in_flight = 1'b1;
      end
    end else if (in_flight) begin
      chk("stable_addr", 32'(sd_addr), 32'(cur.addr));
      chk("stable_be", 32'({sd_wrh, sd_wrl}), 32'(cur.be));
      if (!cur.is_rd) chk("stable_din", 32'(sd_din), 32'(cur.din));
      if (sd_ack == sd_req) in_flight = 1'b0;
    end
    if (host_rvalid) begin
      rvalid_cnt++;
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid actual rdata=0x%0h required=no rvalid", host_rdata);
      end else begin
        chk("rdata", 32'(host_rdata), 32'(exp_rd.pop_front()));
      end
    end
  end

  task automatic host_req(input logic we, input logic [23:0] addr, input logic [1:0] be,
                          input logic [15:0] data, input bit rd_chk, input logic [15:0] rd_exp);
    int n;
    @(negedge clk);
    host_valid = 1'b1; host_we = we; host_addr = addr; host_be = be; host_wdata = data;
    #1;
    n = 0;
    while (!host_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!host_ready) begin
      failures++;
      $display("FAIL host_ready_timeout actual=0 required=1 addr=0x%0h", addr);
    end else begin
      @(posedge clk);
      exp_tog.push_back('{addr: addr, be: (we ? be : 2'b00), din: data, is_rd: !we});
      if (!we && rd_chk) exp_rd.push_back(rd_exp);
    end
    #1 host_valid = 1'b0;
  endtask

  // Streams writes first..last (addr 0x20+k, data 0xC000+k); leaves valid high if stalled.
  task automatic stream(input int first, input int last, input int budget, output int next);
    int k, c;
    k = first; c = 0;
    while (k <= last && c < budget) begin
      @(negedge clk);
      host_valid = 1'b1; host_we = 1'b1; host_be = 2'b11;
      host_addr = 24'(32'h20 + k); host_wdata = 16'(32'hC000 + k);
      #1;
      if (host_ready) begin
        @(posedge clk);
        exp_tog.push_back('{addr: host_addr, be: 2'b11, din: host_wdata, is_rd: 1'b0});
        k++;
        #1 host_valid = 1'b0;
      end
      c++;
    end
    next = k;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(idle && exp_tog.size() == 0 && exp_rd.size() == 0) && n < 500) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL wait_idle_timeout actual idle=%0b tog_q=%0d rd_q=%0d required idle=1 queues empty",
               idle, exp_tog.size(), exp_rd.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, r0, nxt, errcyc;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    // reset values
    chk("rst_sd_req", 32'(sd_req), 32'd0);
    chk("rst_sd_addr", 32'(sd_addr), 32'd0);
    chk("rst_sd_din", 32'(sd_din), 32'd0);
    chk("rst_sd_be", 32'({sd_wrh, sd_wrl}), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ready", 32'(host_ready), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    rst = 1'b0;
    #1;
    chk("sync_ready", 32'(host_ready), 32'd0);
    chk("sync_idle", 32'(idle), 32'd0);
    @(posedge clk); #1;
    chk("post_sync_idle", 32'(idle), 32'd1);
    chk("post_sync_ready", 32'(host_ready), 32'd1);
    chk("post_sync_req", 32'(sd_req), 32'd0);
    mon_en = 1'b1;

    // three writes then a read of the middle one
    t0 = tog_cnt; r0 = rvalid_cnt;
    host_req(1'b1, 24'h000010, 2'b11, 16'hA001, 1'b0, 16'h0);
    host_req(1'b1, 24'h000011, 2'b11, 16'hA002, 1'b0, 16'h0);
    host_req(1'b1, 24'h000012, 2'b11, 16'hA003, 1'b0, 16'h0);
    host_req(1'b0, 24'h000011, 2'b00, 16'h0000, 1'b1, 16'hA002);
    wait_idle();
    chk("seq_toggles", 32'(tog_cnt - t0), 32'd4);
    chk("seq_rvalids", 32'(rvalid_cnt - r0), 32'd1);

    // upper-byte-only write, then read it back
    host_req(1'b1, 24'h123456, 2'b10, 16'hBEEF, 1'b0, 16'h0);
    host_req(1'b0, 24'h123456, 2'b00, 16'h0000, 1'b1, 16'hBE00);
    wait_idle();
    chk("no_err_yet", 32'(err_timeout), 32'd0);

    // backpressure with ack held: 4 queued plus 1 in flight
    ack_hold = 1'b1;
    stream(0, 5, 20, nxt);
    chk("stream_accepted", 32'(nxt), 32'd5);
    chk("full_ready", 32'(host_ready), 32'd0);
    host_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_err", 32'(err_timeout), 32'd1);
    ack_hold = 1'b0;
    stream(5, 5, 100, nxt);
    chk("stream_done", 32'(nxt), 32'd6);
    wait_idle();

    // reset with controller ack high
    ack_preset = 1'b1; ack_preset_en = 1'b1;
    @(negedge clk);
    mon_en = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_req", 32'(sd_req), 32'd0);
    chk("rst2_err", 32'(err_timeout), 32'd0);
    chk("rst2_ready", 32'(host_ready), 32'd0);
    rst = 1'b0; ack_preset_en = 1'b0;
    #1 chk("sync2_ready", 32'(host_ready), 32'd0);
    @(posedge clk); #1;
    chk("sync2_req", 32'(sd_req), 32'd1);
    repeat (5) @(negedge clk);
    chk("sync2_req_held", 32'(sd_req), 32'd1);
    chk("sync2_idle", 32'(idle), 32'd1);
    mon_en = 1'b1;
    host_req(1'b1, 24'h000050, 2'b11, 16'h1234, 1'b0, 16'h0);
    wait_idle();
    chk("sync2_after_write_req", 32'(sd_req), 32'd0);

    // watchdog: no ack
    ack_hold = 1'b1;
    host_req(1'b1, 24'h000060, 2'b11, 16'h5555, 1'b0, 16'h0);
    errcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #3;
      if (err_timeout && errcyc < 0) errcyc = cyc;
    end
    chk("timeout_latency", 32'(errcyc - tog_cyc), 32'd15);
    ack_hold = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err_timeout), 32'd1);

    // reset while a read is pending
    ack_hold = 1'b1;
    r0 = rvalid_cnt;
    host_req(1'b0, 24'h000010, 2'b00, 16'h0000, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rd_pending", 32'(sd_req != sd_ack), 32'd1);
    mon_en = 1'b0; rst = 1'b1;
    #1;
    chk("rst3_req", 32'(sd_req), 32'd0);
    chk("rst3_addr", 32'(sd_addr), 32'd0);
    chk("rst3_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst3_err", 32'(err_timeout), 32'd0);
    chk("rst3_idle", 32'(idle), 32'd0);
    repeat (2) @(negedge clk);
    ack_hold = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("dropped_read_no_rvalid", 32'(rvalid_cnt - r0), 32'd0);
    chk("rst3_idle_after", 32'(idle), 32'd1);
    chk("rst3_aligned", 32'(sd_req == sd_ack), 32'd1);

    chk("tog_queue_empty", 32'(exp_tog.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
